// File: rtl/stall_ctrl.sv
// Hazard and stall controller: load-use detection, a per-register scoreboard for multi-cycle ops,
// an outstanding-op counter, and a fence drain FSM. Stall and flush outputs are combinational.
module stall_ctrl #(
  parameter int unsigned MAX_OUT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [4:0]  Rs1D_i,
  input  logic [4:0]  Rs2D_i,
  input  logic [4:0]  RdE_i,
  input  logic        LoadE_i,
  input  logic        PCSrcE_i,
  input  logic        IssueD_i,
  input  logic [4:0]  IssueRdD_i,
  input  logic        WbV_i,
  input  logic [4:0]  WbRd_i,
  input  logic        FenceD_i,
  output logic        StallF_o,
  output logic        StallD_o,
  output logic        FlushD_o,
  output logic        FlushE_o,
  output logic [31:0] Pending_o,
  output logic [3:0]  OutCnt_o,
  output logic        Err_o
);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  logic [31:0] wb_mask, pend_eff;
  logic        lw_stall, sb_stall, iss_stall, dr_stall, stall;
  logic        cnt_full, cnt_zero, wb_err, wb_ok, fire;

  // Write-first register file: a same-cycle writeback already satisfies its readers.
  assign wb_mask  = WbV_i ? (32'd1 << WbRd_i) : 32'd0;
  assign pend_eff = pending_q & ~wb_mask;

  assign cnt_full = (cnt_q == 4'(MAX_OUT));
  assign cnt_zero = (cnt_q == 4'd0);

  assign lw_stall  = LoadE_i & (RdE_i != 5'd0) & ((RdE_i == Rs1D_i) | (RdE_i == Rs2D_i));
  assign sb_stall  = pend_eff[Rs1D_i] | pend_eff[Rs2D_i];
  assign iss_stall = IssueD_i & (cnt_full | pend_eff[IssueRdD_i]);
  assign dr_stall  = (state_q == StDrain) | (FenceD_i & ~cnt_zero);

  assign stall = (lw_stall | sb_stall | iss_stall | dr_stall) & ~PCSrcE_i & rst_ni;

  assign StallF_o = stall;
  assign StallD_o = stall;
  assign FlushD_o = PCSrcE_i & rst_ni;
  assign FlushE_o = (PCSrcE_i | stall) & rst_ni;

  assign fire   = IssueD_i & ~stall & ~PCSrcE_i & (state_q == StRun);
  // A writeback with nothing outstanding, or to a register not pending, is ignored and flagged.
  assign wb_err = WbV_i & (cnt_zero | ((WbRd_i != 5'd0) & ~pending_q[WbRd_i]));
  assign wb_ok  = WbV_i & ~wb_err;

  always_comb begin
    pending_d = pending_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    if (wb_ok) begin
      pending_d[WbRd_i] = 1'b0;
      cnt_d             = cnt_d - 4'd1;
    end
    if (wb_err) begin
      err_d = 1'b1;
    end
    // Set after clear so a same-cycle reissue of the same rd stays pending.
    if (fire) begin
      if (IssueRdD_i != 5'd0) begin
        pending_d[IssueRdD_i] = 1'b1;
      end
      cnt_d = cnt_d + 4'd1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (FenceD_i & ~cnt_zero & ~PCSrcE_i) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (PCSrcE_i | cnt_zero) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      pending_q <= 32'd0;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign Pending_o = pending_q;
  assign OutCnt_o  = cnt_q;
  assign Err_o     = err_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed bench for stall_ctrl: load-use, scoreboard, full counter, same-cycle events,
// fence drain, branch override, error flag and mid-drain reset.
module tb_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [4:0]  rs1, rs2, rd_e, iss_rd, wb_rd;
  logic        load_e, pcsrc, issue, wb_v, fence;
  logic        stall_f, stall_d, flush_d, flush_e, err;
  logic [31:0] pending;
  logic [3:0]  out_cnt;

  int checks = 0;
  int errors = 0;

  stall_ctrl #(.MAX_OUT(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .Rs1D_i     (rs1),
    .Rs2D_i     (rs2),
    .RdE_i      (rd_e),
    .LoadE_i    (load_e),
    .PCSrcE_i   (pcsrc),
    .IssueD_i   (issue),
    .IssueRdD_i (iss_rd),
    .WbV_i      (wb_v),
    .WbRd_i     (wb_rd),
    .FenceD_i   (fence),
    .StallF_o   (stall_f),
    .StallD_o   (stall_d),
    .FlushD_o   (flush_d),
    .FlushE_o   (flush_e),
    .Pending_o  (pending),
    .OutCnt_o   (out_cnt),
    .Err_o      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd_e = 5'd0; load_e = 1'b0; pcsrc = 1'b0;
    issue = 1'b0; iss_rd = 5'd0; wb_v = 1'b0; wb_rd = 5'd0; fence = 1'b0;
  endtask

  // Inputs change 1ns after the rising edge; combinational checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    idle();
    rst_ni = 1'b0;
    // Reset: outputs forced low even with hazard-causing inputs
    load_e = 1'b1; rd_e = 5'd5; rs1 = 5'd5; pcsrc = 1'b1;
    #3;
    chk("rst_stall_f", 32'(stall_f), 32'd0);
    chk("rst_stall_d", 32'(stall_d), 32'd0);
    chk("rst_flush_d", 32'(flush_d), 32'd0);
    chk("rst_flush_e", 32'(flush_e), 32'd0);
    chk("rst_pending", pending, 32'd0);
    chk("rst_cnt", 32'(out_cnt), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    idle();
    rst_ni = 1'b1;

    // Load-use
    load_e = 1'b1; rd_e = 5'd5; rs1 = 5'd5;
    settle();
    chk("lu_stall_f", 32'(stall_f), 32'd1);
    chk("lu_stall_d", 32'(stall_d), 32'd1);
    chk("lu_flush_e", 32'(flush_e), 32'd1);
    chk("lu_flush_d", 32'(flush_d), 32'd0);
    rs1 = 5'd0; rs2 = 5'd5;
    settle();
    chk("lu_rs2", 32'(stall_d), 32'd1);
    rd_e = 5'd0; rs2 = 5'd0;
    settle();
    chk("lu_x0", 32'(stall_d), 32'd0);
    chk("lu_x0_flush_e", 32'(flush_e), 32'd0);

    // Scoreboard RAW
    idle(); issue = 1'b1; iss_rd = 5'd7;
    settle();
    chk("sb_fire_nostall", 32'(stall_d), 32'd0);
    tick();
    idle();
    chk("sb_pending7", pending, 32'h80);
    chk("sb_cnt1", 32'(out_cnt), 32'd1);
    rs2 = 5'd7;
    settle();
    chk("sb_stall", 32'(stall_d), 32'd1);
    tick();
    chk("sb_stall_hold", 32'(stall_d), 32'd1);
    wb_v = 1'b1; wb_rd = 5'd7;
    settle();
    chk("sb_release", 32'(stall_d), 32'd0);
    tick();
    idle();
    chk("sb_pending_clr", pending, 32'd0);
    chk("sb_cnt0", 32'(out_cnt), 32'd0);

    // Fill to MAX_OUT
    for (int i = 1; i <= 4; i++) begin
      issue = 1'b1; iss_rd = 5'(i);
      tick();
    end
    idle();
    chk("full_cnt4", 32'(out_cnt), 32'd4);
    chk("full_pending", pending, 32'h1E);
    issue = 1'b1; iss_rd = 5'd5;
    settle();
    chk("full_stall", 32'(stall_d), 32'd1);
    tick();
    chk("full_cnt_hold", 32'(out_cnt), 32'd4);
    wb_v = 1'b1; wb_rd = 5'd1;
    settle();
    chk("full_wb_stall", 32'(stall_d), 32'd1);
    tick();
    wb_v = 1'b0;
    settle();
    chk("full_freed_cnt", 32'(out_cnt), 32'd3);
    chk("full_freed_pend", pending, 32'h1C);
    chk("full_freed_nostall", 32'(stall_d), 32'd0);
    tick();
    idle();
    chk("full_refill_cnt", 32'(out_cnt), 32'd4);
    chk("full_refill_pend", pending, 32'h3C);
    // WAW: reissue to a pending rd blocks even with slots free
    wb_v = 1'b1; wb_rd = 5'd2;
    tick();
    idle();
    issue = 1'b1; iss_rd = 5'd3;
    settle();
    chk("waw_stall", 32'(stall_d), 32'd1);
    idle();
    for (int i = 3; i <= 5; i++) begin
      wb_v = 1'b1; wb_rd = 5'(i);
      tick();
    end
    idle();
    chk("drain_cnt0", 32'(out_cnt), 32'd0);
    chk("drain_pend0", pending, 32'd0);

    // Same-cycle fire and writeback to rd 9
    issue = 1'b1; iss_rd = 5'd9;
    tick();
    wb_v = 1'b1; wb_rd = 5'd9;
    settle();
    chk("sim_nostall", 32'(stall_d), 32'd0);
    tick();
    idle();
    chk("sim_pend9", pending, 32'h200);
    chk("sim_cnt1", 32'(out_cnt), 32'd1);
    wb_v = 1'b1; wb_rd = 5'd9;
    tick();
    idle();
    // Fire to x0 counts without a bit
    issue = 1'b1; iss_rd = 5'd0;
    tick();
    idle();
    chk("x0_cnt", 32'(out_cnt), 32'd1);
    chk("x0_pend", pending, 32'd0);
    wb_v = 1'b1; wb_rd = 5'd0;
    tick();
    idle();
    chk("x0_wb_cnt", 32'(out_cnt), 32'd0);
    chk("x0_wb_err", 32'(err), 32'd0);

    // Fence drain
    issue = 1'b1; iss_rd = 5'd10;
    tick();
    iss_rd = 5'd11;
    tick();
    idle();
    chk("fence_cnt2", 32'(out_cnt), 32'd2);
    fence = 1'b1;
    settle();
    chk("fence_stall", 32'(stall_d), 32'd1);
    tick();
    wb_v = 1'b1; wb_rd = 5'd10;
    settle();
    chk("fence_drain1", 32'(stall_d), 32'd1);
    tick();
    wb_rd = 5'd11;
    settle();
    chk("fence_drain2", 32'(stall_d), 32'd1);
    tick();
    wb_v = 1'b0;
    settle();
    chk("fence_cnt0", 32'(out_cnt), 32'd0);
    chk("fence_drain_last", 32'(stall_d), 32'd1);
    tick();
    chk("fence_run", 32'(stall_d), 32'd0);
    idle();

    // Branch during drain
    issue = 1'b1; iss_rd = 5'd12;
    tick();
    idle();
    fence = 1'b1;
    tick();
    pcsrc = 1'b1;
    settle();
    chk("br_stall_d", 32'(stall_d), 32'd0);
    chk("br_flush_d", 32'(flush_d), 32'd1);
    chk("br_flush_e", 32'(flush_e), 32'd1);
    tick();
    idle();
    chk("br_run", 32'(stall_d), 32'd0);
    chk("br_cnt", 32'(out_cnt), 32'd1);

    // Error flag
    wb_v = 1'b1; wb_rd = 5'd12;
    tick();
    wb_rd = 5'd3;
    tick();
    idle();
    chk("err_set", 32'(err), 32'd1);
    chk("err_cnt_sat", 32'(out_cnt), 32'd0);
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    issue = 1'b1; iss_rd = 5'd13;
    tick();
    idle();
    wb_v = 1'b1; wb_rd = 5'd14;
    tick();
    idle();
    chk("err_nopend_cnt", 32'(out_cnt), 32'd1);
    chk("err_nopend_pend", pending, 32'h2000);

    // Reset mid-drain
    fence = 1'b1;
    tick();
    rs1 = 5'd13;
    settle();
    chk("pre_rst_stall", 32'(stall_d), 32'd1);
    rst_ni = 1'b0;
    settle();
    chk("mrst_stall_f", 32'(stall_f), 32'd0);
    chk("mrst_stall_d", 32'(stall_d), 32'd0);
    chk("mrst_flush_e", 32'(flush_e), 32'd0);
    chk("mrst_pending", pending, 32'd0);
    chk("mrst_cnt", 32'(out_cnt), 32'd0);
    chk("mrst_err", 32'(err), 32'd0);
    tick();
    rst_ni = 1'b1;
    settle();
    chk("post_rst_run", 32'(stall_d), 32'd0);
    idle();
    wb_v = 1'b1; wb_rd = 5'd13;
    tick();
    idle();
    chk("post_rst_wb_err", 32'(err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4, giving the maximum outstanding multi-cycle ops (range 1..15).
REQ-002 SHALL have port clk_i, input, 1 bit: the clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have ports Rs1D_i and Rs2D_i, input, 5 bits each: source registers of the instruction in Decode.
REQ-005 SHALL have port RdE_i, input, 5 bits: destination register of the instruction in Execute.
REQ-006 SHALL have port LoadE_i, input, 1 bit: the instruction in Execute is a load.
REQ-007 SHALL have port PCSrcE_i, input, 1 bit: taken branch or jump resolved in Execute.
REQ-008 SHALL have ports IssueD_i (1 bit) and IssueRdD_i (5 bits), inputs: the Decode instruction is a multi-cycle op writing IssueRdD_i.
REQ-009 SHALL have ports WbV_i (1 bit) and WbRd_i (5 bits), inputs: a multi-cycle op completes and writes WbRd_i this cycle.
REQ-010 SHALL have port FenceD_i, input, 1 bit: the Decode instruction requires all multi-cycle ops drained.
REQ-011 SHALL have outputs StallF_o, StallD_o, FlushD_o and FlushE_o, 1 bit each: pipeline control.
REQ-012 SHALL have output Pending_o, 32 bits: registered scoreboard, one bit per register.
REQ-013 SHALL have output OutCnt_o, 4 bits: number of outstanding multi-cycle ops.
REQ-014 SHALL have output Err_o, 1 bit: sticky protocol error.

Function
REQ-015 SHALL never set Pending_o[0]; any source or destination equal to x0 never causes a hazard.
REQ-016 SHALL compute lwStall = LoadE_i & RdE_i!=0 & (RdE_i==Rs1D_i | RdE_i==Rs2D_i).
REQ-017 SHALL compute sbStall = Pending[Rs1D_i] or Pending[Rs2D_i], excluding the register WbRd_i when WbV_i is high in the same cycle (register file is write-first).
REQ-018 SHALL compute issStall = IssueD_i & (OutCnt_o==MAX_OUT or Pending[IssueRdD_i]), the latter after the same-cycle WbV_i exclusion (WAW block).
REQ-019 SHALL compute drStall = FSM in DRAIN state, or FenceD_i with OutCnt_o!=0.
REQ-020 SHALL drive StallF_o = StallD_o = (lwStall | sbStall | issStall | drStall) & !PCSrcE_i, so a branch flush overrides stalls.
REQ-021 SHALL drive FlushD_o = PCSrcE_i and FlushE_o = PCSrcE_i | (StallD_o).
REQ-022 SHALL define issue fire = IssueD_i & !StallD_o & !PCSrcE_i; on fire it sets Pending[IssueRdD_i] (if nonzero) and increments OutCnt_o.
REQ-023 SHALL, when WbV_i is high, clear Pending[WbRd_i] and decrement OutCnt_o.
REQ-024 SHALL apply fire and WbV_i in the same cycle as set-after-clear: same rd ends set, and the count is net unchanged.
REQ-025 SHALL count a fire with IssueRdD_i==0 in OutCnt_o without setting any bit.
REQ-026 SHALL set Err_o, sticky until reset, on WbV_i with OutCnt_o==0, or on WbV_i with WbRd_i!=0 whose Pending bit is clear; the count then saturates at 0 and no state is otherwise altered.
REQ-027 SHALL implement FSM RUN->DRAIN when FenceD_i & OutCnt_o!=0 & !PCSrcE_i.
REQ-028 SHALL implement FSM DRAIN->RUN in the cycle after OutCnt_o reaches 0; PCSrcE_i in DRAIN returns to RUN.
REQ-029 SHALL suppress fire while in DRAIN.
REQ-030 SHALL make all stall and flush outputs combinational from inputs and registered state, with zero-cycle latency.
REQ-031 SHALL register Pending_o and OutCnt_o, updated one cycle after the fire or writeback.

Reset
REQ-032 SHALL, while rst_ni is low, hold Pending_o=0, OutCnt_o=0, Err_o=0 and FSM=RUN asynchronously.
REQ-033 SHALL, while rst_ni is low, force StallF_o, StallD_o, FlushD_o and FlushE_o to 0.
REQ-034 SHALL, on reset asserted mid-operation, discard all outstanding ops without raising Err_o; later writebacks of those ops are error cases.

Verification
REQ-035 SHALL cover load-use: LoadE_i=1, RdE_i=5, Rs1D_i=5 -> StallF_o=StallD_o=FlushE_o=1, FlushD_o=0; with RdE_i=0 -> no stall.
REQ-036 SHALL cover scoreboard: fire rd=7, then Rs2D_i=7 -> StallD_o=1 until WbV_i,WbRd_i=7, which releases in that same cycle; Pending_o[7]=0 next cycle.
REQ-037 SHALL cover full: MAX_OUT=4, four fires to rd 1..4 -> OutCnt_o=4, fifth IssueD_i -> stall; a WbV_i then frees one slot next cycle.
REQ-038 SHALL cover simultaneous events: fire rd=9 and WbV_i rd=9 together -> Pending_o[9]=1 with OutCnt_o unchanged.
REQ-039 SHALL cover fence and branch: FenceD_i with OutCnt_o=2 -> DRAIN and stall until both writebacks, RUN after; PCSrcE_i during stall -> FlushD_o=FlushE_o=1, StallD_o=0.
REQ-040 SHALL cover error and reset: WbV_i rd=3 with OutCnt_o=0 -> Err_o=1 sticky; rst_ni low mid-DRAIN -> all outputs 0 immediately.
